des_iter_core: RTL

- Iterative DES engine, the sequential successor to the combinational single-block DES top.
- Takes one 64-bit block plus a 64-bit key and a per-block encrypt/decrypt select.
- Runs the 16 Feistel rounds over multiple clock cycles and returns the result through valid/ready handshakes.
- Sits between the host-side block buffer and the output register stage of the crypto datapath.

---
 rtl/des_iter_core.sv | 259 +++++++++++++++++++++++++
 1 files changed

// File: rtl/des_iter_core.sv
// -----------------------------------------------------------------------------
// des_iter_core
//   Iterative DES engine. Accepts one 64-bit block, a 64-bit key (parity bits
//   ignored) and an encrypt/decrypt select, then runs the 16 Feistel rounds,
//   ROUNDS_PER_CYCLE rounds per clock. The result is offered on a valid/ready
//   handshake and held until it is taken.
//
// Ports
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   in_valid   block/key/mode presented       in_ready   core can accept (IDLE)
//   e          1 = encrypt, 0 = decrypt        k          64-bit key
//   in         64-bit input block
//   out_valid  result available (DONE)        out_ready  downstream takes result
//   out        64-bit result block             busy       high in RUN or DONE
//
// Bit numbering: DES table bit 1 is the MSB of the corresponding vector.
// -----------------------------------------------------------------------------
module des_iter_core #(
    parameter int ROUNDS_PER_CYCLE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        e,
    input  logic [63:0] k,
    input  logic [63:0] in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out,
    output logic        busy
);
    localparam int RPC = ROUNDS_PER_CYCLE;

    genvar gi;
    generate
        for (gi = 0; gi < 1; gi++) begin : g_rpc_check
            if (!(RPC == 1 || RPC == 2 || RPC == 4 || RPC == 8 || RPC == 16)) begin : g_bad
                $error("des_iter_core: ROUNDS_PER_CYCLE must be 1, 2, 4, 8 or 16");
            end
        end
    endgenerate

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // ---------------- DES tables (1-based bit numbers, MSB = 1) ----------------
    localparam int IP_T [64] = '{58,50,42,34,26,18,10, 2, 60,52,44,36,28,20,12, 4,
                                 62,54,46,38,30,22,14, 6, 64,56,48,40,32,24,16, 8,
                                 57,49,41,33,25,17, 9, 1, 59,51,43,35,27,19,11, 3,
                                 61,53,45,37,29,21,13, 5, 63,55,47,39,31,23,15, 7};
    localparam int FP_T [64] = '{40, 8,48,16,56,24,64,32, 39, 7,47,15,55,23,63,31,
                                 38, 6,46,14,54,22,62,30, 37, 5,45,13,53,21,61,29,
                                 36, 4,44,12,52,20,60,28, 35, 3,43,11,51,19,59,27,
                                 34, 2,42,10,50,18,58,26, 33, 1,41, 9,49,17,57,25};
    localparam int E_T [48]  = '{32, 1, 2, 3, 4, 5,  4, 5, 6, 7, 8, 9,  8, 9,10,11,12,13,
                                 12,13,14,15,16,17, 16,17,18,19,20,21, 20,21,22,23,24,25,
                                 24,25,26,27,28,29, 28,29,30,31,32, 1};
    localparam int P_T [32]  = '{16, 7,20,21,29,12,28,17,  1,15,23,26, 5,18,31,10,
                                  2, 8,24,14,32,27, 3, 9, 19,13,30, 6,22,11, 4,25};
    localparam int PC1_T [56] = '{57,49,41,33,25,17, 9,  1,58,50,42,34,26,18,
                                  10, 2,59,51,43,35,27, 19,11, 3,60,52,44,36,
                                  63,55,47,39,31,23,15,  7,62,54,46,38,30,22,
                                  14, 6,61,53,45,37,29, 21,13, 5,28,20,12, 4};
    localparam int PC2_T [48] = '{14,17,11,24, 1, 5,  3,28,15, 6,21,10,
                                  23,19,12, 4,26, 8, 16, 7,27,20,13, 2,
                                  41,52,31,37,47,55, 30,40,51,45,33,48,
                                  44,49,39,56,34,53, 46,42,50,36,29,32};
    // S-box n entry at index row*16 + col
    localparam int SB [8][64] = '{
        '{14, 4,13, 1, 2,15,11, 8, 3,10, 6,12, 5, 9, 0, 7,  0,15, 7, 4,14, 2,13, 1,10, 6,12,11, 9, 5, 3, 8,
           4, 1,14, 8,13, 6, 2,11,15,12, 9, 7, 3,10, 5, 0, 15,12, 8, 2, 4, 9, 1, 7, 5,11, 3,14,10, 0, 6,13},
        '{15, 1, 8,14, 6,11, 3, 4, 9, 7, 2,13,12, 0, 5,10,  3,13, 4, 7,15, 2, 8,14,12, 0, 1,10, 6, 9,11, 5,
           0,14, 7,11,10, 4,13, 1, 5, 8,12, 6, 9, 3, 2,15, 13, 8,10, 1, 3,15, 4, 2,11, 6, 7,12, 0, 5,14, 9},
        '{10, 0, 9,14, 6, 3,15, 5, 1,13,12, 7,11, 4, 2, 8, 13, 7, 0, 9, 3, 4, 6,10, 2, 8, 5,14,12,11,15, 1,
          13, 6, 4, 9, 8,15, 3, 0,11, 1, 2,12, 5,10,14, 7,  1,10,13, 0, 6, 9, 8, 7, 4,15,14, 3,11, 5, 2,12},
        '{ 7,13,14, 3, 0, 6, 9,10, 1, 2, 8, 5,11,12, 4,15, 13, 8,11, 5, 6,15, 0, 3, 4, 7, 2,12, 1,10,14, 9,
          10, 6, 9, 0,12,11, 7,13,15, 1, 3,14, 5, 2, 8, 4,  3,15, 0, 6,10, 1,13, 8, 9, 4, 5,11,12, 7, 2,14},
        '{ 2,12, 4, 1, 7,10,11, 6, 8, 5, 3,15,13, 0,14, 9, 14,11, 2,12, 4, 7,13, 1, 5, 0,15,10, 3, 9, 8, 6,
           4, 2, 1,11,10,13, 7, 8,15, 9,12, 5, 6, 3, 0,14, 11, 8,12, 7, 1,14, 2,13, 6,15, 0, 9,10, 4, 5, 3},
        '{12, 1,10,15, 9, 2, 6, 8, 0,13, 3, 4,14, 7, 5,11, 10,15, 4, 2, 7,12, 9, 5, 6, 1,13,14, 0,11, 3, 8,
           9,14,15, 5, 2, 8,12, 3, 7, 0, 4,10, 1,13,11, 6,  4, 3, 2,12, 9, 5,15,10,11,14, 1, 7, 6, 0, 8,13},
        '{ 4,11, 2,14,15, 0, 8,13, 3,12, 9, 7, 5,10, 6, 1, 13, 0,11, 7, 4, 9, 1,10,14, 3, 5,12, 2,15, 8, 6,
           1, 4,11,13,12, 3, 7,14,10,15, 6, 8, 0, 5, 9, 2,  6,11,13, 8, 1, 4,10, 7, 9, 5, 0,15,14, 2, 3,12},
        '{13, 2, 8, 4, 6,15,11, 1,10, 9, 3,14, 5, 0,12, 7,  1,15,13, 8,10, 3, 7, 4,12, 5, 6,11, 0,14, 9, 2,
           7,11, 4, 1, 9,12,14, 2, 0, 6,10,13,15, 3, 5, 8,  2, 1,14, 7, 4,10, 8,13,15,12, 9, 0, 3, 5, 6,11}
    };

    // ---------------- permutation helpers ----------------
    function automatic logic [63:0] perm_ip(input logic [63:0] x);
        logic [63:0] o;
        o = '0;
        for (int j = 0; j < 64; j++) o[6'(63 - j)] = x[6'(64 - IP_T[j])];
        return o;
    endfunction

    function automatic logic [63:0] perm_fp(input logic [63:0] x);
        logic [63:0] o;
        o = '0;
        for (int j = 0; j < 64; j++) o[6'(63 - j)] = x[6'(64 - FP_T[j])];
        return o;
    endfunction

    function automatic logic [55:0] perm_pc1(input logic [63:0] x);
        logic [55:0] o;
        o = '0;
        for (int j = 0; j < 56; j++) o[6'(55 - j)] = x[6'(64 - PC1_T[j])];
        return o;
    endfunction

    function automatic logic [47:0] perm_pc2(input logic [55:0] x);
        logic [47:0] o;
        o = '0;
        for (int j = 0; j < 48; j++) o[6'(47 - j)] = x[6'(56 - PC2_T[j])];
        return o;
    endfunction

    // Feistel function f(R, K) = P(S(E(R) xor K))
    function automatic logic [31:0] feistel(input logic [31:0] r, input logic [47:0] sk);
        logic [47:0] x;
        logic [31:0] s;
        logic [31:0] o;
        logic [5:0]  b;
        x = '0;
        for (int j = 0; j < 48; j++) x[6'(47 - j)] = r[5'(32 - E_T[j])];
        x = x ^ sk;
        s = '0;
        for (int n = 0; n < 8; n++) begin
            b = x[6'(47 - 6 * n) -: 6];
            // row = outer bits, column = inner four bits
            s[5'(31 - 4 * n) -: 4] = 4'(SB[n][int'({b[5], b[0], b[4:1]})]);
        end
        o = '0;
        for (int j = 0; j < 32; j++) o[5'(31 - j)] = s[5'(32 - P_T[j])];
        return o;
    endfunction

    // ---------------- state ----------------
    logic [1:0]  state_q, state_d;
    logic [31:0] l_q, l_d, r_q, r_d;
    logic [27:0] c_q, c_d, d_q, d_d;
    logic [4:0]  rnd_q, rnd_d;
    logic        mode_q, mode_d;
    logic [63:0] out_q, out_d;

    // Combinational chain of RPC rounds starting from the registered state
    logic [31:0] l_w, r_w, f_w;
    logic [27:0] c_w, d_w;
    logic [4:0]  rnd_i, rnd_end;
    logic [47:0] subkey;

    always_comb begin
        l_w    = l_q;
        r_w    = r_q;
        c_w    = c_q;
        d_w    = d_q;
        rnd_i  = rnd_q;
        subkey = '0;
        f_w    = '0;
        for (int s = 0; s < RPC; s++) begin
            rnd_i = rnd_q + 5'(s + 1);
            if (mode_q) begin
                // Encrypt: single-bit rotate in rounds 1, 2, 9, 16
                if (rnd_i == 5'd1 || rnd_i == 5'd2 || rnd_i == 5'd9 || rnd_i == 5'd16) begin
                    c_w = {c_w[26:0], c_w[27]};
                    d_w = {d_w[26:0], d_w[27]};
                end else begin
                    c_w = {c_w[25:0], c_w[27:26]};
                    d_w = {d_w[25:0], d_w[27:26]};
                end
            end else if (rnd_i != 5'd1) begin
                // Decrypt walks the schedule backwards: C16 equals C0, so round 1
                // uses the unrotated halves and later rounds undo the encrypt
                // shifts in reverse order (single-bit in rounds 2, 9, 16).
                if (rnd_i == 5'd2 || rnd_i == 5'd9 || rnd_i == 5'd16) begin
                    c_w = {c_w[0], c_w[27:1]};
                    d_w = {d_w[0], d_w[27:1]};
                end else begin
                    c_w = {c_w[1:0], c_w[27:2]};
                    d_w = {d_w[1:0], d_w[27:2]};
                end
            end
            subkey = perm_pc2({c_w, d_w});
            f_w    = l_w ^ feistel(r_w, subkey);
            l_w    = r_w;
            r_w    = f_w;
        end
    end

    assign rnd_end = rnd_q + 5'(RPC);

    always_comb begin
        state_d = state_q;
        l_d     = l_q;
        r_d     = r_q;
        c_d     = c_q;
        d_d     = d_q;
        rnd_d   = rnd_q;
        mode_d  = mode_q;
        out_d   = out_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    {l_d, r_d} = perm_ip(in);
                    {c_d, d_d} = perm_pc1(k);
                    mode_d     = e;
                    rnd_d      = '0;
                    state_d    = S_RUN;
                end
            end
            S_RUN: begin
                l_d   = l_w;
                r_d   = r_w;
                c_d   = c_w;
                d_d   = d_w;
                rnd_d = rnd_end;
                if (rnd_end == 5'd16) begin
                    // Halves swapped before the final permutation
                    out_d   = perm_fp({r_w, l_w});
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            l_q     <= '0;
            r_q     <= '0;
            c_q     <= '0;
            d_q     <= '0;
            rnd_q   <= '0;
            mode_q  <= 1'b0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            l_q     <= l_d;
            r_q     <= r_d;
            c_q     <= c_d;
            d_q     <= d_d;
            rnd_q   <= rnd_d;
            mode_q  <= mode_d;
            out_q   <= out_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign out       = out_q;

endmodule
